// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the pipeline event sources and pipe_ctrl.
// The slave modport is the sequencer's view; master is the core/driver side.
interface pipe_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            load_use;
  logic            ireq_busy;
  logic            dreq_busy;
  logic            mdu_start;
  logic            mdu_done;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;

  logic            stall_f;
  logic            stall_d;
  logic            stall_e;
  logic            stall_m;
  logic            flush_d;
  logic            flush_e;
  logic            flush_m;
  logic            flush_w;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            mdu_timeout;
  logic [1:0]      busy_state;

  modport master (
    output load_use, ireq_busy, dreq_busy, mdu_start, mdu_done,
    output br_valid, br_target, trap_valid, trap_target,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w,
    input  redir_valid, redir_pc, mdu_timeout, busy_state
  );

  modport slave (
    input  load_use, ireq_busy, dreq_busy, mdu_start, mdu_done,
    input  br_valid, br_target, trap_valid, trap_target,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w,
    output redir_valid, redir_pc, mdu_timeout, busy_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises traps, dmem/MDU stalls,
// branch redirects and load-use hazards, and drives a registered PC-redirect channel to fetch.
module pipe_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MDU_TIMEOUT = 70
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave ctrl_io
);

  localparam int unsigned CntW = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StMduWait   = 2'd1,
    StTrapDrain = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic st_f, st_d, st_e, st_m;
  logic fl_d, fl_e, fl_m, fl_w;
  logic flush_d_all;

  always_comb begin
    state_d       = state_q;
    // A pending redirect is consumed in the first cycle fetch is not busy.
    redir_valid_d = redir_valid_q & ctrl_io.ireq_busy;
    redir_pc_d    = redir_pc_q;
    trap_pc_d     = trap_pc_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    st_f = 1'b0;
    st_d = 1'b0;
    st_e = 1'b0;
    st_m = 1'b0;
    fl_d = 1'b0;
    fl_e = 1'b0;
    fl_m = 1'b0;
    fl_w = 1'b0;

    unique case (state_q)
      StRun, StMduWait: begin
        if (ctrl_io.trap_valid && !ctrl_io.dreq_busy) begin
          fl_d          = 1'b1;
          fl_e          = 1'b1;
          fl_m          = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = ctrl_io.trap_target;
          state_d       = StRun;
        end else if (ctrl_io.trap_valid) begin
          st_f      = 1'b1;
          st_d      = 1'b1;
          st_e      = 1'b1;
          st_m      = 1'b1;
          fl_w      = 1'b1;
          trap_pc_d = ctrl_io.trap_target;
          state_d   = StTrapDrain;
        end else if (state_q == StMduWait) begin
          if (ctrl_io.mdu_done) begin
            state_d = StRun;
          end else begin
            st_f = 1'b1;
            st_d = 1'b1;
            st_e = 1'b1;
            fl_m = 1'b1;
            if (cnt_q != CntW'(MDU_TIMEOUT)) begin
              cnt_d = cnt_q + CntW'(1);
            end
            if (cnt_d == CntW'(MDU_TIMEOUT)) begin
              timeout_d = 1'b1;
            end
          end
        end else if (ctrl_io.dreq_busy) begin
          st_f = 1'b1;
          st_d = 1'b1;
          st_e = 1'b1;
          st_m = 1'b1;
          fl_w = 1'b1;
        end else if (ctrl_io.mdu_start && !ctrl_io.mdu_done) begin
          st_f    = 1'b1;
          st_d    = 1'b1;
          st_e    = 1'b1;
          fl_m    = 1'b1;
          cnt_d   = '0;
          state_d = StMduWait;
        end else if (ctrl_io.br_valid && !redir_valid_q) begin
          fl_d          = 1'b1;
          fl_e          = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = ctrl_io.br_target;
        end else if (ctrl_io.load_use) begin
          st_f = 1'b1;
          st_d = 1'b1;
          fl_e = 1'b1;
        end
      end
      StTrapDrain: begin
        // W already holds a bubble here, so a further trap_valid is ignored.
        if (ctrl_io.dreq_busy) begin
          st_f = 1'b1;
          st_d = 1'b1;
          st_e = 1'b1;
          st_m = 1'b1;
          fl_w = 1'b1;
        end else begin
          fl_d          = 1'b1;
          fl_e          = 1'b1;
          fl_m          = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = trap_pc_q;
          state_d       = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // D holds stale fetches while a redirect is pending; the bubble wins over any hold.
  assign flush_d_all = fl_d | redir_valid_q;

  assign ctrl_io.stall_f     = st_f;
  assign ctrl_io.stall_d     = st_d & ~flush_d_all;
  assign ctrl_io.stall_e     = st_e;
  assign ctrl_io.stall_m     = st_m;
  assign ctrl_io.flush_d     = flush_d_all;
  assign ctrl_io.flush_e     = fl_e;
  assign ctrl_io.flush_m     = fl_m;
  assign ctrl_io.flush_w     = fl_w;
  assign ctrl_io.redir_valid = redir_valid_q;
  assign ctrl_io.redir_pc    = redir_pc_q;
  assign ctrl_io.mdu_timeout = timeout_q;
  assign ctrl_io.busy_state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      trap_pc_q     <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      trap_pc_q     <= trap_pc_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl against a cycle-level priority model.
module tb_pipe_ctrl;
  localparam int unsigned XLEN = 64;
  localparam int          TO   = 70;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if #(.XLEN(XLEN)) bus ();

  pipe_ctrl #(.XLEN(XLEN), .MDU_TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: mode 0 run, 1 waiting on MDU, 2 draining dmem before a trap redirect.
  int          m_mode;
  bit          m_rv;
  logic [63:0] m_rpc;
  logic [63:0] m_tpc;
  int          m_wait;
  bit          m_to;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    bus.load_use    = 1'b0;
    bus.ireq_busy   = 1'b0;
    bus.dreq_busy   = 1'b0;
    bus.mdu_start   = 1'b0;
    bus.mdu_done    = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.trap_valid  = 1'b0;
    bus.trap_target = '0;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_rv   = 1'b0;
    m_rpc  = '0;
    m_tpc  = '0;
    m_wait = 0;
    m_to   = 1'b0;
  endtask

  // One clock: inputs are already applied; compare mid-cycle, then advance the model.
  task automatic tick();
    int          depth;    // how many leading stages (F, D, E, M) are held
    logic [3:0]  fl;       // {d, e, m, w}
    bit          redir;
    logic [63:0] rtgt;
    logic [3:0]  exp_st;
    logic [3:0]  exp_fl;
    #3;
    if (reset) begin
      model_reset();
    end else begin
      check_eq("busy_state", {62'd0, bus.busy_state}, m_mode);
      check_eq("redir_valid", {63'd0, bus.redir_valid}, {63'd0, m_rv});
      check_eq("redir_pc", bus.redir_pc, m_rpc);
      check_eq("mdu_timeout", {63'd0, bus.mdu_timeout}, {63'd0, m_to});

      depth = 0;
      fl    = 4'b0000;
      redir = 1'b0;
      rtgt  = '0;
      if (m_mode == 2) begin
        if (bus.dreq_busy) begin
          depth = 4; fl = 4'b0001;
        end else begin
          fl = 4'b1110; redir = 1'b1; rtgt = m_tpc; m_mode = 0;
        end
      end else if (bus.trap_valid) begin
        if (!bus.dreq_busy) begin
          fl = 4'b1110; redir = 1'b1; rtgt = bus.trap_target; m_mode = 0;
        end else begin
          depth = 4; fl = 4'b0001; m_tpc = bus.trap_target; m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (bus.mdu_done) begin
          m_mode = 0;
        end else begin
          depth = 3; fl = 4'b0010; m_wait++;
          if (m_wait >= TO) m_to = 1'b1;
        end
      end else if (bus.dreq_busy) begin
        depth = 4; fl = 4'b0001;
      end else if (bus.mdu_start && !bus.mdu_done) begin
        depth = 3; fl = 4'b0010; m_mode = 1; m_wait = 0;
      end else if (bus.br_valid && !m_rv) begin
        fl = 4'b1100; redir = 1'b1; rtgt = bus.br_target;
      end else if (bus.load_use) begin
        depth = 2; fl = 4'b0100;
      end

      exp_fl    = fl | (m_rv ? 4'b1000 : 4'b0000);
      exp_st[3] = (depth >= 1);
      exp_st[2] = (depth >= 2) && !exp_fl[3];
      exp_st[1] = (depth >= 3);
      exp_st[0] = (depth >= 4);
      check_eq("stall_fdem", {60'd0, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m},
               {60'd0, exp_st});
      check_eq("flush_demw", {60'd0, bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w},
               {60'd0, exp_fl});

      if (redir) begin
        m_rv  = 1'b1;
        m_rpc = rtgt;
      end else begin
        m_rv = m_rv && bus.ireq_busy;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_inputs();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    idle(2);

    // Load-use for one cycle.
    bus.load_use = 1'b1;
    tick();
    idle(2);

    // Branch while fetch is busy for three cycles.
    bus.br_valid  = 1'b1;
    bus.br_target = 64'h8000_0040;
    bus.ireq_busy = 1'b1;
    tick();
    check_eq("t2_redir_pc", bus.redir_pc, 64'h8000_0040);
    bus.br_valid = 1'b0;
    tick();
    tick();
    check_eq("t2_redir_held", {63'd0, bus.redir_valid}, 64'd1);
    bus.ireq_busy = 1'b0;
    tick();
    check_eq("t2_redir_clear", {63'd0, bus.redir_valid}, 64'd0);
    idle(2);

    // MDU finishing 34 cycles after start.
    bus.mdu_start = 1'b1;
    tick();
    bus.mdu_start = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    check_eq("t3_in_wait", {62'd0, bus.busy_state}, 64'd1);
    bus.mdu_done = 1'b1;
    tick();
    bus.mdu_done = 1'b0;
    check_eq("t3_back_run", {62'd0, bus.busy_state}, 64'd0);
    check_eq("t3_no_timeout", {63'd0, bus.mdu_timeout}, 64'd0);
    idle(2);

    // MDU that never finishes, then a reset while waiting.
    bus.mdu_start = 1'b1;
    tick();
    bus.mdu_start = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check_eq("t3_timeout_early", {63'd0, bus.mdu_timeout}, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    check_eq("t3_timeout_set", {63'd0, bus.mdu_timeout}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t7_mdu_rst_state", {62'd0, bus.busy_state}, 64'd0);
    check_eq("t7_mdu_rst_to", {63'd0, bus.mdu_timeout}, 64'd0);
    idle(2);

    // Trap while dmem busy for five cycles.
    bus.trap_valid  = 1'b1;
    bus.trap_target = 64'h8000_0100;
    bus.dreq_busy   = 1'b1;
    tick();
    bus.trap_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t4_draining", {62'd0, bus.busy_state}, 64'd2);
    bus.dreq_busy = 1'b0;
    tick();
    check_eq("t4_redir_pc", bus.redir_pc, 64'h8000_0100);
    check_eq("t4_redir_valid", {63'd0, bus.redir_valid}, 64'd1);
    idle(3);

    // Trap, branch and load-use together.
    bus.trap_valid  = 1'b1;
    bus.trap_target = 64'h8000_0200;
    bus.br_valid    = 1'b1;
    bus.br_target   = 64'h8000_0300;
    bus.load_use    = 1'b1;
    tick();
    check_eq("t5_trap_wins", bus.redir_pc, 64'h8000_0200);
    idle(3);

    // Trap overriding a pending branch redirect.
    bus.br_valid  = 1'b1;
    bus.br_target = 64'h8000_0400;
    bus.ireq_busy = 1'b1;
    tick();
    clr_inputs();
    bus.ireq_busy   = 1'b1;
    bus.trap_valid  = 1'b1;
    bus.trap_target = 64'h8000_0500;
    tick();
    check_eq("t6_trap_over_br", bus.redir_pc, 64'h8000_0500);
    idle(3);

    // Reset in TRAP_DRAIN with a redirect pending.
    bus.ireq_busy   = 1'b1;
    bus.br_valid    = 1'b1;
    bus.br_target   = 64'h8000_0600;
    tick();
    bus.br_valid    = 1'b0;
    bus.trap_valid  = 1'b1;
    bus.trap_target = 64'h8000_0700;
    bus.dreq_busy   = 1'b1;
    tick();
    bus.trap_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr_inputs();
    check_eq("t7_drain_rst_state", {62'd0, bus.busy_state}, 64'd0);
    check_eq("t7_drain_rst_rv", {63'd0, bus.redir_valid}, 64'd0);
    check_eq("t7_drain_rst_pc", bus.redir_pc, 64'd0);
    #3;
    check_eq("t7_rst_outs", {56'd0, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
             bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w}, 64'd0);
    @(posedge clk);
    #1;

    // Random traffic with sparse events and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(299) == 0);
      bus.load_use    = ($urandom_range(3) == 0);
      bus.ireq_busy   = ($urandom_range(2) == 0);
      bus.dreq_busy   = ($urandom_range(4) == 0);
      bus.mdu_start   = ($urandom_range(15) == 0);
      bus.mdu_done    = ($urandom_range(9) == 0);
      bus.br_valid    = ($urandom_range(4) == 0);
      bus.br_target   = {$urandom, $urandom};
      bus.trap_valid  = ($urandom_range(19) == 0);
      bus.trap_target = {$urandom, $urandom};
      tick();
    end
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
- Combines these event sources into per-stage stall and flush controls plus one registered PC-redirect channel to fetch:
  - load-use stall from the hazard unit
  - multi-cycle MDU occupancy
  - imem/dmem busy handshakes
  - branch resolution in E
  - traps committed in W
- Sits beside the hazard unit in the core top.

Parameters:
- XLEN, 64, PC/data width.
- MDU_TIMEOUT, 70, maximum MDU_WAIT cycles before the sticky error flag is raised.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- load_use  in  1  load-use stall request from hazard unit (consumer in D)
- ireq_busy  in  1  fetch access outstanding; F cannot accept a redirect
- dreq_busy  in  1  M-stage data access outstanding
- mdu_start  in  1  pulse: mul/div entered E this cycle
- mdu_done  in  1  pulse: MDU result ready
- br_valid  in  1  E-stage branch/jump mispredicted
- br_target  in  XLEN  redirect target for br_valid
- trap_valid  in  1  W-stage commits exception, interrupt or mret
- trap_target  in  XLEN  mtvec or mepc target
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into the stage register
- redir_valid  out  1  registered redirect request to fetch
- redir_pc  out  XLEN  registered redirect target
- mdu_timeout  out  1  sticky error flag
- busy_state  out  2  FSM state, for debug

Behaviour:
- FSM states: RUN=0, MDU_WAIT=1, TRAP_DRAIN=2. Reset goes to RUN.
- Reset values: all stall/flush outputs 0, redir_valid 0, redir_pc 0, mdu_timeout 0, counter 0.
- Priority in RUN, evaluated each cycle (first match wins):
  1. trap_valid && !dreq_busy: flush_d, flush_e, flush_m = 1. Load redir_pc=trap_target, redir_valid=1 next cycle.
  2. trap_valid && dreq_busy: stall_f..stall_m = 1, flush_w = 1. Latch trap_target; go to TRAP_DRAIN.
  3. dreq_busy: stall_f, stall_d, stall_e, stall_m = 1, flush_w = 1.
  4. mdu_start && !mdu_done: stall_f, stall_d, stall_e = 1, flush_m = 1. Go to MDU_WAIT; counter cleared.
  5. br_valid: flush_d = 1, flush_e = 1. Load redir_pc=br_target, redir_valid=1 next cycle.
  6. load_use: stall_f = 1, stall_d = 1, flush_e = 1.
- A branch is acted on only in a cycle where E advances. Under a higher-priority stall, br_valid is held by the stalled E register and is re-evaluated later.
- MDU_WAIT:
  - Assert stall_f, stall_d, stall_e and flush_m; counter increments.
  - mdu_done: in that same cycle drop stall/flush_m; return to RUN.
  - trap_valid overrides and is handled as in RUN rules 1/2; the MDU result is discarded and the state leaves MDU_WAIT.
  - Counter reaching MDU_TIMEOUT sets mdu_timeout, which is cleared only by reset. The state stays in MDU_WAIT.
- TRAP_DRAIN:
  - Hold stall_f..stall_m = 1 and flush_w = 1 while dreq_busy.
  - First cycle with !dreq_busy: flush_d, flush_e, flush_m = 1; issue redirect with the latched target; return to RUN.
  - A second trap_valid is ignored (W holds a bubble).
- Redirect channel:
  - redir_valid stays 1 until a cycle with !ireq_busy (fetch accepts), then clears the next cycle.
  - While redir_valid=1, flush_d = 1 every cycle, which discards the stale fetch.
  - A trap redirect arriving while a branch redirect is pending overwrites redir_pc; trap wins.
  - br_valid cannot arrive while redir_valid is pending: E only holds a bubble then. If it does, it is ignored.
- Simultaneous events:
  - trap beats branch and load_use.
  - branch beats load_use: the load_use consumer is wrong-path.
  - stall_x and flush_x are never both 1 for the same stage.
- Reset mid-operation (MDU_WAIT or TRAP_DRAIN, pending redirect): return to RUN next cycle with all outputs at reset values.

Test Plan:
1. Load-use: load_use=1 for 1 cycle, other inputs 0 -> stall_f=stall_d=flush_e=1 for exactly that cycle; everything else 0.
2. Branch with busy fetch: br_valid=1, br_target=0x8000_0040, ireq_busy=1 for 3 cycles -> flush_d/flush_e=1 in cycle 0. Then redir_valid=1 with redir_pc=0x8000_0040 and flush_d=1 for cycles 1-3; redir_valid clears in cycle 4.
3. MDU: mdu_start, then mdu_done 34 cycles later -> busy_state=1 and stall_f/d/e=flush_m=1 for 34 cycles; RUN again on the done cycle; mdu_timeout stays 0. With no mdu_done -> mdu_timeout=1 after 70 cycles and stays set.
4. Trap during dmem access: trap_valid with trap_target=0x8000_0100 while dreq_busy=1 for 5 cycles -> TRAP_DRAIN with all four stalls for 5 cycles. Next cycle flush_d/e/m=1; redir_pc=0x8000_0100 on the following cycle.
5. Simultaneous: trap_valid, br_valid and load_use in one cycle -> redir_pc=trap_target; no load_use stall.
6. Trap redirect overriding a pending branch redirect (ireq_busy=1) -> redir_pc=trap_target.
7. Reset pulse in MDU_WAIT or TRAP_DRAIN -> next cycle busy_state=0, redir_valid=0, all stall/flush=0.
